// File: rtl/gcd_pkg.sv
// Shared types and helpers for the gcd_engine codebase slice.
// GCD_BINARY_EN selects the binary (Stein) step in gcd_datapath.
package gcd_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic a_zero;
      logic b_zero;
      logic eq;
      logic gt;
   } cmp_flags_t;

   // Width of the common power-of-two shift count k.
   function automatic int K_W(input int width);
      return $clog2(width) + 1;
   endfunction

endpackage

// File: rtl/gcd_datapath.sv
// Operand registers, comparator, iteration step and result/err registers for gcd_engine.
// Define GCD_BINARY_EN for the binary (Stein) step with k shift; default is subtractive Euclid.
module gcd_datapath
   import gcd_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             step,
   input  logic             latch,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output cmp_flags_t       flags,
   output logic [WIDTH-1:0] result,
   output logic             err
);

   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] diff_ab;
   logic [WIDTH-1:0] diff_ba;
   logic [WIDTH-1:0] final_val;

   assign flags.a_zero = (a_q == '0);
   assign flags.b_zero = (b_q == '0);
   assign flags.eq     = (a_q == b_q);
   assign flags.gt     = (a_q > b_q);

   // Only the difference with the larger minuend is ever used, so neither wraps.
   assign diff_ab = a_q - b_q;
   assign diff_ba = b_q - a_q;

`ifdef GCD_BINARY_EN
   localparam int KW = K_W(WIDTH);
   logic [KW-1:0] k_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q <= '0;
         b_q <= '0;
         k_q <= '0;
      end else if (load) begin
         a_q <= a_in;
         b_q <= b_in;
         k_q <= '0;
      end else if (step) begin
         if (!a_q[0] && !b_q[0]) begin
            a_q <= a_q >> 1;
            b_q <= b_q >> 1;
            k_q <= k_q + 1'b1;
         end else if (!a_q[0]) begin
            a_q <= a_q >> 1;
         end else if (!b_q[0]) begin
            b_q <= b_q >> 1;
         end else if (flags.gt) begin
            a_q <= diff_ab >> 1;
         end else begin
            b_q <= diff_ba >> 1;
         end
      end
   end

   // The common factor 2^k removed while both were even is restored here.
   assign final_val = a_q << k_q;
`else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q <= '0;
         b_q <= '0;
      end else if (load) begin
         a_q <= a_in;
         b_q <= b_in;
      end else if (step) begin
         if (flags.gt) begin
            a_q <= diff_ab;
         end else begin
            b_q <= diff_ba;
         end
      end
   end

   assign final_val = a_q;
`endif

   // A zero operand can only come from the load, so k is still 0 on those paths.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result <= '0;
         err    <= 1'b0;
      end else if (load) begin
         err <= 1'b0;
      end else if (latch) begin
         err <= flags.a_zero & flags.b_zero;
         if (flags.a_zero) begin
            result <= b_q;
         end else if (flags.b_zero) begin
            result <= a_q;
         end else begin
            result <= final_val;
         end
      end
   end

endmodule

// File: rtl/gcd_engine.sv
// Two-operand GCD engine: controller FSM around gcd_datapath with start/busy/done handshake.
// GCD_BINARY_EN switches the iteration to the binary (Stein) step; ports are unchanged.
module gcd_engine
   import gcd_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             err
);

   state_t     state_q;
   state_t     state_d;
   cmp_flags_t flags;
   logic       load;
   logic       step;
   logic       latch;
   logic       finish;

   assign finish = flags.a_zero | flags.b_zero | flags.eq;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // start is looked at only in IDLE, so requests during CALC/DONE are dropped.
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      step    = 1'b0;
      latch   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               load    = 1'b1;
               state_d = CALC;
            end
         end
         CALC: begin
            if (finish) begin
               latch   = 1'b1;
               state_d = DONE;
            end else begin
               step = 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign busy = (state_q == CALC);
   assign done = (state_q == DONE);

   gcd_datapath #(
      .WIDTH (WIDTH)
   ) u_datapath (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (load),
      .step   (step),
      .latch  (latch),
      .a_in   (a_in),
      .b_in   (b_in),
      .flags  (flags),
      .result (result),
      .err    (err)
   );

endmodule

// File: doc/gcd_engine.md
Name: gcd_engine

Overview:
- Parametrised successor to the two-operand GCD datapath/controller pair.
- Operands are loaded in parallel in one cycle with a start/busy/done handshake.
- Degenerate operands (zero inputs) are handled and flagged.
- Holds the result until the next operation.
- Built-time option swaps the subtractive (Euclid) iteration for the binary (Stein) iteration to cut the cycle count.

Parameters:
- WIDTH, 16, operand and result width in bits (>= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- a_in  input  WIDTH  operand A; captured when start is accepted.
- b_in  input  WIDTH  operand B; captured when start is accepted.
- busy  output  1  high while state is CALC.
- done  output  1  one-cycle pulse; result is valid.
- result  output  WIDTH  GCD; held from the done pulse until the next accepted start.
- err  output  1  set with done when both operands are 0; cleared on the next accepted start.

Behaviour:
- Reset (rst_n low, asynchronous, any state, including mid-CALC):
  - state = IDLE.
  - Operand registers cleared; shift count k cleared.
  - busy = 0, done = 0, result = 0, err = 0.
- FSM states: IDLE, CALC, DONE.
  - IDLE: on an edge with start = 1, load A <= a_in, B <= b_in, k <= 0, clear err, go to CALC. Otherwise stay in IDLE.
  - CALC: one evaluation per clock edge, in priority order:
    1. A == 0 and B == 0: result <= 0, err <= 1, go to DONE.
    2. A == 0: result <= B, go to DONE.
    3. B == 0: result <= A, go to DONE.
    4. A == B: result <= A << k, go to DONE.
    5. Otherwise, apply one iteration step (see below) and stay in CALC.
  - DONE: done = 1 for this single cycle, busy = 0, return to IDLE unconditionally.
- start handling:
  - start in CALC or DONE is ignored; it is not queued.
  - Earliest next acceptance is the edge that leaves DONE.
- Subtractive step (default):
  - If A > B: A <= A - B. Otherwise B <= B - A.
  - k stays 0.
- Operand zero can occur only at load; an iteration step never produces 0.
- Latency: with N CALC evaluations (including the terminating one), done is high in the cycle after the N-th evaluation edge. The start edge is edge 0.
- All arithmetic is unsigned, WIDTH bits; subtraction never underflows because the larger operand is always the minuend.
- Width of k: $clog2(WIDTH)+1 bits. The k shift never exceeds WIDTH-1.

Optional Feature:
- Macro: GCD_BINARY_EN.
- Defined: the CALC step (rule 5) becomes Stein's binary step:
  - Both A and B even: A >>= 1, B >>= 1, k++.
  - Else if A even: A >>= 1.
  - Else if B even: B >>= 1.
  - Else if A > B: A <= (A - B) >> 1.
  - Else: B <= (B - A) >> 1.
  - The termination rules and result = A << k are unchanged.
- Undefined: subtractive step only; the k register and shifter are omitted and result = A.
- Port list is identical in both builds.

Decomposition:
- Package gcd_pkg:
  - state enum (IDLE, CALC, DONE).
  - K_W function ($clog2(WIDTH)+1).
  - comparison-flag struct (a_zero, b_zero, eq, gt).
- Sub-module gcd_datapath: A/B/k registers, comparator flags, subtractor, shifters, result register; driven by load/step/latch strobes.
- The top level gcd_engine contains the controller FSM.

Test Plan:
- a=17, b=5, start one cycle -> subtractive: result = 1, done after 7 evaluations, busy high 7 cycles. Binary: done after 5 evaluations.
- a=48, b=18 -> result = 6, err = 0. Subtractive: 5 evaluations. Binary: 6 evaluations, k = 1 at termination.
- a=0, b=9 -> result = 9 after 1 evaluation. a=0, b=0 -> result = 0, err = 1, done pulses once.
- a=65535, b=65535 (WIDTH=16) -> result = 65535 after 1 evaluation, no overflow.
- a=17, b=5, then start pulsed with a=4, b=2 during CALC -> pulse ignored, result = 1. Subsequent start with a=4, b=2 -> result = 2, err = 0.
- a=48, b=18, rst_n low for 1 cycle mid-CALC -> busy, done, result, err all 0 immediately. A new start with a=48, b=18 completes normally with result = 6.
